contador_monitor: RTL and testbench
===================================

// Module: contador_monitor
// PURPOSE
//   Passive checker on the output side of an up-counter. Watches the counter's
//   enable and count bus and verifies the counter's step rule (+1 when enabled, hold otherwise).
//   Reports lock status, error pulses, a saturating error count and wrap-around events.
//   Sits beside any WIDTH-bit enabled up-counter in self-checking benches and
//   built-in self-test paths.
// PARAMETERS
//   WIDTH       8   width of observed count bus
//   LOCK_COUNT  4   consecutive matching compares needed to declare lock (1..15)
// PORTS
//   clk         in   1      rising-edge clock, same clock as observed counter
//   rst         in   1      asynchronous reset, active-high
//   en_obs      in   1      enable presented to the observed counter
//   cnt_in      in   WIDTH  observed counter output
//   clr_err     in   1      synchronous clear of err_count
//   locked      out  1      counter follows step rule (state LOCKED)
//   err_pulse   out  1      one-cycle pulse on mismatch while LOCKED
//   wrap_pulse  out  1      one-cycle pulse on valid all-ones -> 0 step
//   err_count   out  8      saturating error count
//   expected    out  WIDTH  predicted next value: cnt_in + en_obs (mod 2^WIDTH)
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-high.
//   - rst=1 takes effect immediately, including mid-operation:
//     - state=IDLE, good_cnt=0, history cleared.
//     - locked=0, err_pulse=0, wrap_pulse=0, err_count=0, expected=0.
//   - Sampling at each rising edge k:
//     - capture prev_cnt<=cnt_in(k) and prev_en<=en_obs(k).
//     - compare: match = (cnt_in(k) == prev_cnt + prev_en), sum truncated to WIDTH bits.
//   - All outputs are registered. The result of the edge-k compare is visible from
//     edge k until edge k+1 (single-cycle pulse width).
//   - expected <= cnt_in(k) + en_obs(k), mod 2^WIDTH.
//   - FSM:
//     - IDLE: no history. First edge after reset release only captures samples,
//       with no compare -> ACQUIRE, good_cnt=0.
//     - ACQUIRE:
//       - match: good_cnt+1. When good_cnt reaches LOCK_COUNT -> LOCKED and locked=1.
//       - mismatch: good_cnt=0, stay in ACQUIRE. No err_pulse, err_count unchanged.
//     - LOCKED:
//       - match: stay in LOCKED.
//       - mismatch: err_pulse=1, err_count+1, -> ACQUIRE, good_cnt=0, locked=0
//         (locked drops together with err_pulse).
//   - wrap_pulse=1 when prev_cnt is all ones, prev_en=1, cnt_in=0, and state is not IDLE.
//     It fires in ACQUIRE and LOCKED, and is never an error.
//   - err_count saturates at 255 and never wraps.
//   - clr_err=1 clears err_count to 0. If an error occurs in the same cycle,
//     err_count=1 (error wins over clear).
//   - en_obs=0 with cnt_in unchanged is a match. en_obs=0 with cnt_in changed is a mismatch.
//   - No X-propagation handling: inputs are assumed driven after reset release.
// TESTING
//   1. Reset: rst=1, then en_obs=1, cnt_in=0,1,2..., release rst.
//      -> locked=1 after the 5th sampling edge (1 capture + 4 matches).
//      -> err_count=0.
//   2. Wrap: locked, cnt_in 0xFE,0xFF,0x00 with en_obs=1.
//      -> wrap_pulse high exactly 1 cycle after the 0x00 sample.
//      -> locked stays 1, err_pulse=0.
//   3. Hold/skip: locked, en_obs=0, cnt_in held 0x37 for 3 edges -> no error.
//      Then cnt_in=0x38 with prev_en=0 -> err_pulse 1 cycle, err_count=1, locked=0.
//   4. Acquire glitch: during ACQUIRE (good_cnt=2) inject cnt_in jump 0x05->0x09.
//      -> no err_pulse, err_count=0.
//      -> lock takes 4 further matches.
//   5. Saturation/clear: force 256 errors -> err_count=255.
//      clr_err=1 alone -> 0. clr_err=1 with error in the same cycle -> 1.
//   6. Async reset mid-run: assert rst between clock edges while locked, err_count=3.
//      -> all outputs 0 before the next edge.
//      -> relock per test 1 after release.

Source files
------------

// File: rtl/contador_monitor_if.sv
// Observation bundle between an enabled up-counter and its step-rule monitor.
// The master side drives the counter samples; the slave side is the monitor.
interface contador_monitor_if #(
   parameter int WIDTH = 8
);
   logic             en_obs;
   logic [WIDTH-1:0] cnt_in;
   logic             clr_err;
   logic             locked;
   logic             err_pulse;
   logic             wrap_pulse;
   logic [7:0]       err_count;
   logic [WIDTH-1:0] expected;

   modport master (
      output en_obs, cnt_in, clr_err,
      input  locked, err_pulse, wrap_pulse, err_count, expected
   );

   modport slave (
      input  en_obs, cnt_in, clr_err,
      output locked, err_pulse, wrap_pulse, err_count, expected
   );
endinterface

// File: rtl/contador_monitor.sv
// Passive checker for a WIDTH-bit enabled up-counter: verifies +1/hold steps,
// reports lock, error pulses, a saturating error count and wrap events.
module contador_monitor #(
   parameter int WIDTH      = 8,
   parameter int LOCK_COUNT = 4
) (
   input  logic               clk,
   input  logic               rst,
   contador_monitor_if.slave  mon
);

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   state_t           state_q, state_d;
   logic [3:0]       good_q, good_d;
   logic [WIDTH-1:0] prev_cnt_q;
   logic             prev_en_q;
   logic             locked_q, locked_d;
   logic             errp_q, errp_d;
   logic             wrap_q, wrap_d;
   logic [7:0]       errc_q, errc_d;
   logic [WIDTH-1:0] exp_q, exp_d;

   logic [WIDTH-1:0] pred;
   logic             match;
   logic             err_evt;

   assign pred  = prev_cnt_q + WIDTH'(prev_en_q);
   assign match = (mon.cnt_in == pred);

   always_comb begin
      state_d  = state_q;
      good_d   = good_q;
      locked_d = 1'b0;
      err_evt  = 1'b0;
      case (state_q)
         IDLE: begin
            // first edge only seeds the history
            state_d = ACQUIRE;
            good_d  = 4'd0;
         end
         ACQUIRE: begin
            if (match) begin
               good_d = good_q + 4'd1;
               if (good_q + 4'd1 == 4'(LOCK_COUNT)) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
               end
            end else begin
               good_d = 4'd0;
            end
         end
         LOCKED: begin
            if (match) begin
               locked_d = 1'b1;
            end else begin
               err_evt = 1'b1;
               state_d = ACQUIRE;
               good_d  = 4'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      errp_d = err_evt;
      wrap_d = (state_q != IDLE) && prev_en_q && (&prev_cnt_q) && (mon.cnt_in == '0);
      exp_d  = mon.cnt_in + WIDTH'(mon.en_obs);
      errc_d = errc_q;
      // an error in the same cycle as a clear leaves a count of one
      if (err_evt) begin
         if (mon.clr_err)          errc_d = 8'd1;
         else if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
      end else if (mon.clr_err) begin
         errc_d = 8'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         good_q     <= 4'd0;
         prev_cnt_q <= '0;
         prev_en_q  <= 1'b0;
         locked_q   <= 1'b0;
         errp_q     <= 1'b0;
         wrap_q     <= 1'b0;
         errc_q     <= 8'd0;
         exp_q      <= '0;
      end else begin
         state_q    <= state_d;
         good_q     <= good_d;
         prev_cnt_q <= mon.cnt_in;
         prev_en_q  <= mon.en_obs;
         locked_q   <= locked_d;
         errp_q     <= errp_d;
         wrap_q     <= wrap_d;
         errc_q     <= errc_d;
         exp_q      <= exp_d;
      end
   end

   assign mon.locked     = locked_q;
   assign mon.err_pulse  = errp_q;
   assign mon.wrap_pulse = wrap_q;
   assign mon.err_count  = errc_q;
   assign mon.expected   = exp_q;

endmodule

// File: tb/tb_contador_monitor.sv
// Scoreboard bench for contador_monitor: directed counter traces with hand-derived
// expectations queued by the stimulus and checked by an independent monitor.
module tb_contador_monitor;

   typedef struct {
      logic       lk;
      logic       ep;
      logic       wp;
      logic [7:0] ec;
      logic [7:0] ex;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];

   contador_monitor_if #(.WIDTH(8)) bus();

   contador_monitor #(.WIDTH(8), .LOCK_COUNT(4)) dut (
      .clk (clk),
      .rst (rst),
      .mon (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask

   // monitor: every sampling edge presents a new output set
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("locked",     {31'd0, bus.locked},     {31'd0, e.lk});
         chk("err_pulse",  {31'd0, bus.err_pulse},  {31'd0, e.ep});
         chk("wrap_pulse", {31'd0, bus.wrap_pulse}, {31'd0, e.wp});
         chk("err_count",  {24'd0, bus.err_count},  {24'd0, e.ec});
         chk("expected",   {24'd0, bus.expected},   {24'd0, e.ex});
      end
   end

   // called at a falling edge; drives the sample for the next rising edge
   task automatic step(input logic en, input logic [7:0] c, input logic clr,
                       input logic lk, input logic ep, input logic wp, input logic [7:0] ec);
      exp_t e;
      bus.en_obs  = en;
      bus.cnt_in  = c;
      bus.clr_err = clr;
      e.lk = lk; e.ep = ep; e.wp = wp; e.ec = ec;
      e.ex = c + {7'd0, en};
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_locked"},     {31'd0, bus.locked},     32'd0);
      chk({tag, "_err_pulse"},  {31'd0, bus.err_pulse},  32'd0);
      chk({tag, "_wrap_pulse"}, {31'd0, bus.wrap_pulse}, 32'd0);
      chk({tag, "_err_count"},  {24'd0, bus.err_count},  32'd0);
      chk({tag, "_expected"},   {24'd0, bus.expected},   32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.en_obs = 1'b1; bus.cnt_in = 8'd0; bus.clr_err = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_zero("rst");
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] ec;
      bus.en_obs = 1'b0; bus.cnt_in = 8'd0; bus.clr_err = 1'b0;

      // reset and first lock: capture + 4 matches
      do_reset();
      step(1, 8'h00, 0, 0, 0, 0, 0);
      step(1, 8'h01, 0, 0, 0, 0, 0);
      step(1, 8'h02, 0, 0, 0, 0, 0);
      step(1, 8'h03, 0, 0, 0, 0, 0);
      step(1, 8'h04, 0, 1, 0, 0, 0);
      step(1, 8'h05, 0, 1, 0, 0, 0);

      // hold then illegal change while disabled
      do_reset();
      step(1, 8'h33, 0, 0, 0, 0, 0);
      step(1, 8'h34, 0, 0, 0, 0, 0);
      step(1, 8'h35, 0, 0, 0, 0, 0);
      step(1, 8'h36, 0, 0, 0, 0, 0);
      step(0, 8'h37, 0, 1, 0, 0, 0);
      step(0, 8'h37, 0, 1, 0, 0, 0);
      step(0, 8'h37, 0, 1, 0, 0, 0);
      step(0, 8'h38, 0, 0, 1, 0, 1);
      step(1, 8'h38, 0, 0, 0, 0, 1);

      // glitch during acquire is silent and restarts the lock count
      do_reset();
      step(1, 8'h03, 0, 0, 0, 0, 0);
      step(1, 8'h04, 0, 0, 0, 0, 0);
      step(1, 8'h05, 0, 0, 0, 0, 0);
      step(1, 8'h09, 0, 0, 0, 0, 0);
      step(1, 8'h0A, 0, 0, 0, 0, 0);
      step(1, 8'h0B, 0, 0, 0, 0, 0);
      step(1, 8'h0C, 0, 0, 0, 0, 0);
      step(1, 8'h0D, 0, 1, 0, 0, 0);

      // wrap while locked
      do_reset();
      step(1, 8'hFA, 0, 0, 0, 0, 0);
      step(1, 8'hFB, 0, 0, 0, 0, 0);
      step(1, 8'hFC, 0, 0, 0, 0, 0);
      step(1, 8'hFD, 0, 0, 0, 0, 0);
      step(1, 8'hFE, 0, 1, 0, 0, 0);
      step(1, 8'hFF, 0, 1, 0, 0, 0);
      step(1, 8'h00, 0, 1, 0, 1, 0);
      step(1, 8'h01, 0, 1, 0, 0, 0);

      // 256 errors, each followed by a relock; count pins at 255
      for (int i = 1; i <= 256; i++) begin
         ec = (i > 255) ? 8'hFF : 8'(i);
         step(1, 8'h10, 0, 0, 1, 0, ec);
         step(1, 8'h11, 0, 0, 0, 0, ec);
         step(1, 8'h12, 0, 0, 0, 0, ec);
         step(1, 8'h13, 0, 0, 0, 0, ec);
         step(1, 8'h14, 0, 1, 0, 0, ec);
      end
      step(1, 8'h15, 1, 1, 0, 0, 8'd0);
      step(1, 8'h10, 1, 0, 1, 0, 8'd1);

      // build up err_count=3 while locked, then reset between edges
      ec = 8'd1;
      for (int k = 0; k < 3; k++) begin
         for (int j = 1; j <= 4; j++)
            step(1, 8'h10 + 8'(j), 0, (j == 4), 0, 0, ec);
         if (k < 2) begin
            ec = ec + 8'd1;
            step(1, 8'h10, 0, 0, 1, 0, ec);
         end
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_zero("async");
      do_reset();
      step(1, 8'h00, 0, 0, 0, 0, 0);
      step(1, 8'h01, 0, 0, 0, 0, 0);
      step(1, 8'h02, 0, 0, 0, 0, 0);
      step(1, 8'h03, 0, 0, 0, 0, 0);
      step(1, 8'h04, 0, 1, 0, 0, 0);

      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
